// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding.
package adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used as the bit-slice of the serial adder.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic C,
    output logic S,
    output logic Co
);

    assign S  = A ^ B ^ C;
    assign Co = (A & B) | (C & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder slice, LSB first, carry held in a flop.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_reg;
    logic [WIDTH-1:0] sh_a_reg;
    logic [WIDTH-1:0] sh_b_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;
    logic             fa_s;
    logic             fa_co;

    full_adder u_fa (
        .A  (sh_a_reg[0]),
        .B  (sh_b_reg[0]),
        .C  (carry_reg),
        .S  (fa_s),
        .Co (fa_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            sh_a_reg  <= '0;
            sh_b_reg  <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sh_a_reg  <= a;
                        sh_b_reg  <= b;
                        carry_reg <= cin;
                        cnt_reg   <= '0;
                        sum       <= '0;
                        busy      <= 1'b1;
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Result bits enter at the MSB so after WIDTH shifts bit 0 lands at sum[0].
                    sum       <= {fa_s, sum[WIDTH-1:1]};
                    carry_reg <= fa_co;
                    sh_a_reg  <= {1'b0, sh_a_reg[WIDTH-1:1]};
                    sh_b_reg  <= {1'b0, sh_b_reg[WIDTH-1:1]};
                    cnt_reg   <= cnt_reg + CW'(1);
                    if (cnt_reg == LAST_BIT) begin
                        cout      <= fa_co;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done      <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8 (vector table + corner sequences) and WIDTH=4 (exhaustive).
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       cin4 = 1'b0;
    logic       busy4;
    logic       done4;
    logic [3:0] sum4;
    logic       cout4;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder #(.WIDTH(8)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_adder #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Start one WIDTH=8 addition, scramble the operand inputs while it runs, check timing and result.
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        input logic [7:0] es, input logic ec, input string nm);
        int bc;
        int guard;
        @(negedge clk);
        a = ta; b = tb; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~ta; b = tb ^ 8'h5A; cin = ~tc;
        bc = 0;
        guard = 0;
        while (!done && guard < 40) begin
            if (busy) bc++;
            @(negedge clk);
            guard++;
        end
        chk({nm, " done_seen"}, {31'd0, done}, 32'd1);
        chk({nm, " busy_cycles"}, bc, 32'd8);
        chk({nm, " busy_at_done"}, {31'd0, busy}, 32'd0);
        chk({nm, " sum"}, {24'd0, sum}, {24'd0, es});
        chk({nm, " cout"}, {31'd0, cout}, {31'd0, ec});
        $display("txn %s a=%02h b=%02h cin=%0b -> sum=%02h cout=%0b busy_cycles=%0d",
                 nm, ta, tb, tc, sum, cout, bc);
        @(negedge clk);
        chk({nm, " done_pulse_width"}, {31'd0, done}, 32'd0);
        chk({nm, " sum_held"}, {24'd0, sum}, {24'd0, es});
    endtask

    task automatic run4(input logic [3:0] ta, input logic [3:0] tb, input logic tc);
        logic [4:0] exp;
        int bc;
        int guard;
        exp = {1'b0, ta} + {1'b0, tb} + {4'd0, tc};
        @(negedge clk);
        a4 = ta; b4 = tb; cin4 = tc; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        bc = 0;
        guard = 0;
        while (!done4 && guard < 20) begin
            if (busy4) bc++;
            @(negedge clk);
            guard++;
        end
        chk("w4 done_seen", {31'd0, done4}, 32'd1);
        chk("w4 busy_cycles", bc, 32'd4);
        chk("w4 result", {27'd0, cout4, sum4}, {27'd0, exp});
        $display("txn w4 a=%0h b=%0h cin=%0b -> cout,sum=%02h", ta, tb, tc, {cout4, sum4});
        @(negedge clk);
    endtask

    initial begin
        int t1;
        int t2;
        int dcount;
        int guard;

        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'h7F, 8'h80, 1'b1, 8'h00, 1'b1};
        vecs[3] = '{8'h3C, 8'h5A, 1'b1, 8'h97, 1'b0};
        vecs[4] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0};
        vecs[5] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
        vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[7] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};
        vecs[8] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[9] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst sum", {24'd0, sum}, 32'd0);
        chk("rst cout", {31'd0, cout}, 32'd0);
        chk("rst w4 outputs", {25'd0, busy4, done4, cout4, sum4}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].co, $sformatf("vec%0d", i));
        end

        // start held high: one result, next accept WIDTH+2 cycles later
        @(negedge clk);
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        guard = 0;
        while (!busy && guard < 10) begin @(negedge clk); guard++; end
        t1 = cyc;
        dcount = 0;
        guard = 0;
        while (!done && guard < 20) begin @(negedge clk); guard++; end
        chk("hold done_seen", {31'd0, done}, 32'd1);
        chk("hold sum", {24'd0, sum}, 32'h02);
        chk("hold cout", {31'd0, cout}, 32'd0);
        guard = 0;
        while (busy == 1'b0 && guard < 20) begin
            if (done) dcount++;
            @(negedge clk);
            guard++;
        end
        t2 = cyc;
        chk("hold single_done", dcount, 32'd1);
        chk("hold accept_spacing", t2 - t1, 32'd10);
        $display("txn hold a=01 b=01 -> sum=%02h accepts at %0d and %0d", sum, t1, t2);
        start = 1'b0;
        guard = 0;
        while (!done && guard < 20) begin @(negedge clk); guard++; end
        @(negedge clk);

        // Reset asserted mid-operation
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst partial_sum", {24'd0, sum}, 32'hE0);
        chk("midrst busy_before", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst busy", {31'd0, busy}, 32'd0);
        chk("midrst done", {31'd0, done}, 32'd0);
        chk("midrst sum", {24'd0, sum}, 32'd0);
        chk("midrst cout", {31'd0, cout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst idle_after", {30'd0, busy, done}, 32'd0);
        $display("txn midrst -> outputs cleared, idle");
        run8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, "post_rst");

        // WIDTH=4 exhaustive
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = i[8:0];
            run4(v[3:0], v[7:4], v[8]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
